// File: rtl/crc_stream_arbiter_if.sv
// Bundle of the signals between NUM_REQ packet sources, the shared CRC-32
// generator and the checksum return path.
//   req_*          : per-requester Avalon-ST style beats (valid/sop/eop/empty/data) and ready
//   crc_* (to gen) : crc_datavalid/crc_sop/crc_eop/crc_empty/crc_data forwarded stream
//   crc_valid/crc_checksum : result coming back from the generator
//   res_valid/res_checksum : one-hot strobe and checksum steered to the owning requester
//   tag_err        : sticky flag, a result arrived with no outstanding packet
// Modport slave is taken by the arbiter, modport master by its environment.
interface crc_stream_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_sop;
  logic [NUM_REQ-1:0]             req_eop;
  logic [NUM_REQ*EMPTY_WIDTH-1:0] req_empty;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           crc_datavalid;
  logic                           crc_sop;
  logic                           crc_eop;
  logic [EMPTY_WIDTH-1:0]         crc_empty;
  logic [DATA_WIDTH-1:0]          crc_data;
  logic                           crc_valid;
  logic [31:0]                    crc_checksum;
  logic [NUM_REQ-1:0]             res_valid;
  logic [31:0]                    res_checksum;
  logic                           tag_err;

  modport slave (
    input  req_valid, req_sop, req_eop, req_empty, req_data, crc_valid, crc_checksum,
    output req_ready, crc_datavalid, crc_sop, crc_eop, crc_empty, crc_data,
           res_valid, res_checksum, tag_err
  );

  modport master (
    output req_valid, req_sop, req_eop, req_empty, req_data, crc_valid, crc_checksum,
    input  req_ready, crc_datavalid, crc_sop, crc_eop, crc_empty, crc_data,
           res_valid, res_checksum, tag_err
  );
endinterface

// File: rtl/crc_stream_arbiter.sv
// Shares one CRC-32 generator between NUM_REQ packet sources.
// A whole packet is granted at a time (round robin over requesters presenting
// an SOP beat), its beats are forwarded to the generator through one register
// stage, and the owner's index is queued in an in-order tag FIFO so that each
// checksum coming back can be steered to the requester that sent the packet.
// Ports: clk, reset_n (synchronous, active low), bus (slave side of
// crc_stream_arbiter_if carrying request, generator and result signals).
module crc_stream_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  crc_stream_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(TAG_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_r;
  logic [IDW-1:0]         grant_r;
  logic [IDW-1:0]         ptr_r;
  logic [NUM_REQ-1:0]     req_ready_r;
  logic                   crc_datavalid_r;
  logic                   crc_sop_r;
  logic                   crc_eop_r;
  logic [EMPTY_WIDTH-1:0] crc_empty_r;
  logic [DATA_WIDTH-1:0]  crc_data_r;

  logic [IDW-1:0]         tag_mem_r [TAG_DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [PW:0]            tag_cnt_r;
  logic [NUM_REQ-1:0]     res_valid_r;
  logic [31:0]            res_checksum_r;
  logic                   tag_err_r;

  logic                   accept_s;
  logic                   tag_push_s;
  logic                   tag_pop_s;
  logic                   can_grant_s;
  logic                   grant_hit_s;
  logic [IDW-1:0]         grant_idx_s;
  logic [IDW-1:0]         next_ptr_s;
  logic [IDW-1:0]         cand_idx_s;
  int                     cand_s;
  logic [EMPTY_WIDTH-1:0] sel_empty_s;
  logic [DATA_WIDTH-1:0]  sel_data_s;

  // req_ready_r is only ever one-hot on the owner while BUSY, so this is the owner's handshake.
  assign accept_s    = |(bus.req_valid & req_ready_r);
  assign tag_push_s  = accept_s & bus.req_eop[grant_r];
  assign tag_pop_s   = bus.crc_valid & (tag_cnt_r != {(PW+1){1'b0}});
  assign can_grant_s = tag_cnt_r < (PW+1)'(TAG_DEPTH);
  assign sel_empty_s = bus.req_empty[int'(grant_r)*EMPTY_WIDTH +: EMPTY_WIDTH];
  assign sel_data_s  = bus.req_data[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr_s  = (grant_idx_s == IDW'(NUM_REQ-1)) ? {IDW{1'b0}} : grant_idx_s + IDW'(1'b1);

  // Round-robin search: first requester with a valid SOP at or after ptr_r, wrapping.
  always_comb begin
    grant_hit_s = 1'b0;
    grant_idx_s = {IDW{1'b0}};
    cand_s      = 0;
    cand_idx_s  = {IDW{1'b0}};
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = int'(ptr_r) + off;
      if (cand_s >= NUM_REQ) begin
        cand_s = cand_s - NUM_REQ;
      end else begin
        cand_s = cand_s;
      end
      cand_idx_s = IDW'(cand_s);
      if (!grant_hit_s && bus.req_valid[cand_idx_s] && bus.req_sop[cand_idx_s]) begin
        grant_hit_s = 1'b1;
        grant_idx_s = cand_idx_s;
      end else begin
        grant_hit_s = grant_hit_s;
      end
    end
  end

  // Packet FSM with registered ready, plus the one-stage forwarding register to the generator.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r         <= IDLE;
      grant_r         <= {IDW{1'b0}};
      ptr_r           <= {IDW{1'b0}};
      req_ready_r     <= {NUM_REQ{1'b0}};
      crc_datavalid_r <= 1'b0;
      crc_sop_r       <= 1'b0;
      crc_eop_r       <= 1'b0;
      crc_empty_r     <= {EMPTY_WIDTH{1'b0}};
      crc_data_r      <= {DATA_WIDTH{1'b0}};
    end else begin
      crc_datavalid_r <= accept_s;
      crc_sop_r       <= accept_s & bus.req_sop[grant_r];
      crc_eop_r       <= accept_s & bus.req_eop[grant_r];
      if (accept_s) begin
        crc_empty_r <= sel_empty_s;
        crc_data_r  <= sel_data_s;
      end
      case (state_r)
        IDLE: begin
          if (grant_hit_s && can_grant_s) begin
            state_r     <= BUSY;
            grant_r     <= grant_idx_s;
            ptr_r       <= next_ptr_s;
            req_ready_r <= NUM_REQ'(1'b1) << grant_idx_s;
          end
        end
        BUSY: begin
          // A mid-packet SOP is just forwarded; only EOP ends ownership.
          if (tag_push_s) begin
            state_r     <= IDLE;
            req_ready_r <= {NUM_REQ{1'b0}};
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

  // In-order tag FIFO of packet owners and the registered checksum return path.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_r[i] <= {IDW{1'b0}};
      end
      wr_ptr_r       <= {PW{1'b0}};
      rd_ptr_r       <= {PW{1'b0}};
      tag_cnt_r      <= {(PW+1){1'b0}};
      res_valid_r    <= {NUM_REQ{1'b0}};
      res_checksum_r <= 32'h0000_0000;
      tag_err_r      <= 1'b0;
    end else begin
      if (tag_push_s) begin
        tag_mem_r[wr_ptr_r] <= grant_r;
        wr_ptr_r            <= wr_ptr_r + PW'(1'b1);
      end
      if (tag_pop_s) begin
        rd_ptr_r       <= rd_ptr_r + PW'(1'b1);
        res_valid_r    <= NUM_REQ'(1'b1) << tag_mem_r[rd_ptr_r];
        res_checksum_r <= bus.crc_checksum;
      end else begin
        res_valid_r    <= {NUM_REQ{1'b0}};
      end
      // A result with nothing outstanding is dropped and flagged until reset.
      if (bus.crc_valid && !tag_pop_s) begin
        tag_err_r <= 1'b1;
      end
      case ({tag_push_s, tag_pop_s})
        2'b10:   tag_cnt_r <= tag_cnt_r + (PW+1)'(1'b1);
        2'b01:   tag_cnt_r <= tag_cnt_r - (PW+1)'(1'b1);
        default: tag_cnt_r <= tag_cnt_r;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_r;
  assign bus.crc_datavalid = crc_datavalid_r;
  assign bus.crc_sop       = crc_sop_r;
  assign bus.crc_eop       = crc_eop_r;
  assign bus.crc_empty     = crc_empty_r;
  assign bus.crc_data      = crc_data_r;
  assign bus.res_valid     = res_valid_r;
  assign bus.res_checksum  = res_checksum_r;
  assign bus.tag_err       = tag_err_r;
endmodule

// File: tb/tb_crc_stream_arbiter.sv
// Self-checking bench for crc_stream_arbiter: randomized requesters and a
// generator emulator, checked every cycle against a packet/queue level model,
// plus directed scenarios with constant expectations.
module tb_crc_stream_arbiter;
  localparam int NR    = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
    logic [31:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  crc_stream_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(32), .EMPTY_WIDTH(2)) bus ();

  crc_stream_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(32), .EMPTY_WIDTH(2), .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // stimulus state
  beat_t       drv_q [NR][$];
  bit          drv_v [NR];
  logic        drv_sop [NR];
  logic        drv_eop [NR];
  logic [1:0]  drv_emp [NR];
  logic [31:0] drv_data [NR];
  bit          drv_crc_valid;
  logic [31:0] drv_crc_chk;
  int          gate_pct = 100;
  bit          gen_en = 1'b0;
  int          gen_q [$];
  logic [31:0] chk_q [$];
  bit          force_pulse = 1'b0;
  logic [31:0] force_chk = 32'h0;

  // reference model state
  int          m_owner = -1;
  int          m_ptr = 0;
  int          m_tags [$];
  bit          m_tag_err = 1'b0;
  int          m_acc = -1;
  logic [3:0]  exp_ready = 4'h0;
  logic        exp_dv = 1'b0, exp_sop = 1'b0, exp_eop = 1'b0;
  logic [1:0]  exp_emp = 2'h0;
  logic [31:0] exp_data = 32'h0;
  logic [3:0]  exp_res = 4'h0;
  logic [31:0] exp_chk = 32'h0;

  // observation logs for directed checks
  logic [31:0] res_log_v [$];
  logic [31:0] res_log_c [$];
  logic [31:0] ready_log [$];
  logic [3:0]  prev_ready = 4'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [31:0] log_at(input logic [31:0] q [$], input int idx);
    if (idx < q.size()) return q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic push_beat(input int r, input logic s, input logic e, input logic [1:0] em,
                           input logic [31:0] d);
    beat_t b;
    b.sop = s; b.eop = e; b.emp = em; b.data = d;
    drv_q[r].push_back(b);
  endtask

  task automatic push_rand_pkt(input int r);
    int len;
    len = int'($urandom_range(5, 1));
    for (int j = 0; j < len; j++) begin
      push_beat(r, (j == 0) || ($urandom_range(15) == 0), (j == len - 1),
                (j == len - 1) ? 2'($urandom_range(3)) : 2'h0, $urandom);
    end
  endtask

  // Present head beats (randomly gated), junk when idle, and the generator result.
  task automatic drive();
    logic [3:0]   v, s, e;
    logic [7:0]   em;
    logic [127:0] d;
    bit           fire;
    logic [31:0]  fchk;
    for (int i = 0; i < NR; i++) begin
      drv_v[i] = 1'b0;
      drv_sop[i] = 1'($urandom); drv_eop[i] = 1'($urandom);
      drv_emp[i] = 2'($urandom); drv_data[i] = $urandom;
      if (drv_q[i].size() > 0 && int'($urandom_range(99)) < gate_pct) begin
        drv_v[i] = 1'b1;
        drv_sop[i] = drv_q[i][0].sop; drv_eop[i] = drv_q[i][0].eop;
        drv_emp[i] = drv_q[i][0].emp; drv_data[i] = drv_q[i][0].data;
      end
      v[i] = drv_v[i]; s[i] = drv_sop[i]; e[i] = drv_eop[i];
      em[i*2 +: 2] = drv_emp[i]; d[i*32 +: 32] = drv_data[i];
    end
    fire = force_pulse;
    fchk = force_chk;
    for (int k = 0; k < gen_q.size(); k++) gen_q[k] = gen_q[k] - 1;
    if (gen_q.size() > 0 && gen_q[0] <= 0) begin
      void'(gen_q.pop_front());
      fire = 1'b1;
      if (chk_q.size() > 0) fchk = chk_q.pop_front();
      else fchk = $urandom;
    end
    drv_crc_valid = fire;
    drv_crc_chk = fire ? fchk : $urandom;
    bus.req_valid = v; bus.req_sop = s; bus.req_eop = e;
    bus.req_empty = em; bus.req_data = d;
    bus.crc_valid = drv_crc_valid; bus.crc_checksum = drv_crc_chk;
  endtask

  // Reference: packet ownership, round-robin pointer and a queue of owner IDs.
  task automatic model_step();
    int size0, t;
    bit found;
    if (!reset_n) begin
      m_owner = -1; m_ptr = 0; m_tags.delete(); m_tag_err = 1'b0; m_acc = -1;
      exp_ready = 4'h0; exp_dv = 1'b0; exp_sop = 1'b0; exp_eop = 1'b0;
      exp_emp = 2'h0; exp_data = 32'h0; exp_res = 4'h0; exp_chk = 32'h0;
      return;
    end
    size0 = m_tags.size();
    m_acc = (m_owner >= 0 && drv_v[m_owner]) ? m_owner : -1;
    exp_dv = (m_acc >= 0);
    exp_sop = exp_dv ? drv_sop[m_acc] : 1'b0;
    exp_eop = exp_dv ? drv_eop[m_acc] : 1'b0;
    if (exp_dv) begin
      exp_emp = drv_emp[m_acc];
      exp_data = drv_data[m_acc];
    end
    exp_res = 4'h0;
    if (drv_crc_valid) begin
      if (size0 > 0) begin
        t = m_tags.pop_front();
        exp_res = 4'(1 << t);
        exp_chk = drv_crc_chk;
      end else begin
        m_tag_err = 1'b1;
      end
    end
    if (m_owner >= 0) begin
      if (exp_dv && exp_eop) begin
        m_tags.push_back(m_owner);
        m_owner = -1;
      end
    end else if (size0 < DEPTH) begin
      found = 1'b0;
      for (int k = 0; k < NR; k++) begin
        t = (m_ptr + k) % NR;
        if (!found && drv_v[t] && drv_sop[t]) begin
          found = 1'b1;
          m_owner = t;
        end
      end
      if (found) m_ptr = (m_owner + 1) % NR;
    end
    exp_ready = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
  endtask

  task automatic compare_all();
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check_eq("crc_datavalid", 32'(bus.crc_datavalid), 32'(exp_dv));
    if (exp_dv) begin
      check_eq("crc_sop", 32'(bus.crc_sop), 32'(exp_sop));
      check_eq("crc_eop", 32'(bus.crc_eop), 32'(exp_eop));
      check_eq("crc_empty", 32'(bus.crc_empty), 32'(exp_emp));
      check_eq("crc_data", bus.crc_data, exp_data);
    end
    check_eq("res_valid", 32'(bus.res_valid), 32'(exp_res));
    if (exp_res != 4'h0) check_eq("res_checksum", bus.res_checksum, exp_chk);
    check_eq("tag_err", 32'(bus.tag_err), 32'(m_tag_err));
    if (bus.res_valid != 4'h0) begin
      res_log_v.push_back(32'(bus.res_valid));
      res_log_c.push_back(bus.res_checksum);
    end
    if (bus.req_ready != 4'h0 && prev_ready == 4'h0) ready_log.push_back(32'(bus.req_ready));
    prev_ready = bus.req_ready;
  endtask

  task automatic cycle();
    drive();
    @(posedge clk);
    model_step();
    if (m_acc >= 0) void'(drv_q[m_acc].pop_front());
    if (gen_en && exp_dv && exp_eop) gen_q.push_back(3);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_logs();
    res_log_v.delete(); res_log_c.delete(); ready_log.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) drv_q[i].delete();
    gen_q.delete(); chk_q.delete(); force_pulse = 1'b0;
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    drive();
    do_reset();
    check_eq("reset_ready", 32'(bus.req_ready), 32'h0);
    check_eq("reset_tag_err", 32'(bus.tag_err), 32'h0);

    // single 3-beat packet on requester 2
    gen_en = 1'b1; gate_pct = 100;
    push_beat(2, 1'b1, 1'b0, 2'h0, 32'h1111_1111);
    push_beat(2, 1'b0, 1'b0, 2'h0, 32'h2222_2222);
    push_beat(2, 1'b0, 1'b1, 2'h0, 32'h3333_3333);
    chk_q.push_back(32'hCBF4_3926);
    run(15);
    check_eq("t1_grant", log_at(ready_log, 0), 32'h4);
    check_eq("t1_res_count", 32'(res_log_v.size()), 32'd1);
    check_eq("t1_res_valid", log_at(res_log_v, 0), 32'h4);
    check_eq("t1_res_checksum", log_at(res_log_c, 0), 32'hCBF4_3926);

    // all four requesters at once, two rounds
    do_reset();
    for (int rnd = 0; rnd < 2; rnd++)
      for (int i = 0; i < NR; i++) push_beat(i, 1'b1, 1'b1, 2'($urandom), $urandom);
    run(40);
    for (int k = 0; k < 8; k++) check_eq("t2_rr_order", log_at(ready_log, k), 32'(1 << (k % NR)));
    check_eq("t2_res_count", 32'(res_log_v.size()), 32'd8);

    // tag FIFO full blocks further grants until a result returns
    do_reset();
    gen_en = 1'b0;
    for (int i = 0; i < NR; i++) push_beat(i, 1'b1, 1'b1, 2'h0, $urandom);
    push_beat(0, 1'b1, 1'b1, 2'h0, $urandom);
    run(30);
    check_eq("t3_grants_before", 32'(ready_log.size()), 32'd4);
    check_eq("t3_blocked_ready", 32'(bus.req_ready), 32'h0);
    force_pulse = 1'b1; force_chk = 32'h5A5A_0000;
    cycle();
    force_pulse = 1'b0;
    run(8);
    check_eq("t3_res_valid", log_at(res_log_v, 0), 32'h1);
    check_eq("t3_res_checksum", log_at(res_log_c, 0), 32'h5A5A_0000);
    check_eq("t3_late_grant", log_at(ready_log, 4), 32'h1);

    // checksum ordering req1 then req3
    do_reset();
    gen_en = 1'b1;
    push_beat(1, 1'b1, 1'b0, 2'h0, $urandom);
    push_beat(1, 1'b0, 1'b1, 2'h1, $urandom);
    push_beat(3, 1'b1, 1'b1, 2'h2, $urandom);
    chk_q.push_back(32'hAAAA_0001);
    chk_q.push_back(32'hBBBB_0003);
    run(30);
    check_eq("t4_res0_valid", log_at(res_log_v, 0), 32'h2);
    check_eq("t4_res0_checksum", log_at(res_log_c, 0), 32'hAAAA_0001);
    check_eq("t4_res1_valid", log_at(res_log_v, 1), 32'h8);
    check_eq("t4_res1_checksum", log_at(res_log_c, 1), 32'hBBBB_0003);

    // reset in the middle of a packet with a tag already in flight
    do_reset();
    gen_en = 1'b0;
    push_beat(3, 1'b1, 1'b1, 2'h0, $urandom);
    run(6);
    for (int j = 0; j < 4; j++) push_beat(1, (j == 0), (j == 3), 2'h0, $urandom);
    for (int w = 0; w < 20 && drv_q[1].size() > 3; w++) cycle();
    check_eq("t5_first_beat_taken", 32'(drv_q[1].size()), 32'd3);
    do_reset();
    check_eq("t5_rst_ready", 32'(bus.req_ready), 32'h0);
    check_eq("t5_rst_dv", 32'(bus.crc_datavalid), 32'h0);
    check_eq("t5_rst_data", bus.crc_data, 32'h0);
    check_eq("t5_rst_res", 32'(bus.res_valid), 32'h0);
    gen_en = 1'b1;
    push_beat(0, 1'b1, 1'b1, 2'h3, $urandom);
    run(20);
    check_eq("t5_grant", log_at(ready_log, 0), 32'h1);
    check_eq("t5_res_count", 32'(res_log_v.size()), 32'd1);
    check_eq("t5_res_valid", log_at(res_log_v, 0), 32'h1);

    // result with an empty tag FIFO
    do_reset();
    force_pulse = 1'b1; force_chk = $urandom;
    cycle();
    force_pulse = 1'b0;
    cycle();
    check_eq("t6_tag_err_set", 32'(bus.tag_err), 32'h1);
    check_eq("t6_no_res", 32'(res_log_v.size()), 32'd0);
    gate_pct = 70;
    for (int i = 0; i < NR; i++) push_rand_pkt(i);
    run(80);
    check_eq("t6_tag_err_held", 32'(bus.tag_err), 32'h1);

    // randomized soak against the model
    do_reset();
    gen_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++)
        if (drv_q[i].size() == 0 && $urandom_range(3) == 0) push_rand_pkt(i);
      gate_pct = 50 + int'($urandom_range(50));
      cycle();
    end
    run(60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
